// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe
//   Pipelined barrel shifter with four modes (SHL, SHR, SAR, ROL). It has one
//   register stage per shift-amount bit, and stage k shifts by 2**k. There is a
//   single global stall: every stage advances together, so order is kept and
//   bubbles are carried along rather than collapsed.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous drop of every in-flight operation
//   in_valid/in_ready   operand handshake (in_ready = !out_valid || out_ready)
//   in_data, in_amt     operand and shift amount (0..WIDTH-1)
//   in_op               00 SHL, 01 SHR, 10 SAR, 11 ROL
//   out_valid/out_ready result handshake
//   out_data            shifted result (registered)
//   out_cout            OR of all operand bits shifted out; 0 for ROL
//   out_zero            out_data == 0
module shift_unit_pipe #(
  parameter  int WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_SAR = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("shift_unit_pipe: WIDTH must be a power of two and at least 2");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    // R: amount bits still pending on entry to this stage; bit 0 is ours.
    localparam int          R  = SW - k;
    localparam int unsigned S  = 1 << k;
    localparam int unsigned SR = WIDTH - S;
    localparam logic [WIDTH-1:0] SIGN_FILL = ~({WIDTH{1'b1}} >> S);

    logic [WIDTH-1:0] d_in;
    logic [R-1:0]     a_in;
    op_e              o_in;
    logic             sg_in;
    logic             st_in;
    logic             v_in;

    logic [WIDTH-1:0] d_nxt;
    logic             st_nxt;

    logic [WIDTH-1:0] q_data;
    logic             q_sticky;
    logic             q_valid;

    if (k == 0) begin : g_src
      assign d_in  = in_data;
      assign a_in  = in_amt;
      assign o_in  = op_e'(in_op);
      assign sg_in = in_data[WIDTH-1];
      assign st_in = 1'b0;
      assign v_in  = in_valid & advance;
    end else begin : g_src
      assign d_in  = g_stage[k-1].q_data;
      assign a_in  = g_stage[k-1].g_fwd.q_amt;
      assign o_in  = g_stage[k-1].g_fwd.q_op;
      assign sg_in = g_stage[k-1].g_fwd.q_sign;
      assign st_in = g_stage[k-1].q_sticky;
      assign v_in  = g_stage[k-1].q_valid;
    end

    // Bits pushed out here are always original operand bits: the total shift
    // never exceeds WIDTH-1, so earlier fill bits cannot reach the far edge.
    always_comb begin
      d_nxt  = d_in;
      st_nxt = st_in;
      if (a_in[0]) begin
        case (o_in)
          OP_SHL: begin
            d_nxt  = d_in << S;
            st_nxt = st_in | (|d_in[WIDTH-1 -: S]);
          end
          OP_SHR: begin
            d_nxt  = d_in >> S;
            st_nxt = st_in | (|d_in[S-1:0]);
          end
          OP_SAR: begin
            d_nxt  = (d_in >> S) | (sg_in ? SIGN_FILL : '0);
            st_nxt = st_in | (|d_in[S-1:0]);
          end
          OP_ROL: begin
            d_nxt  = (d_in << S) | (d_in >> SR);
            st_nxt = 1'b0;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_valid  <= 1'b0;
        q_data   <= '0;
        q_sticky <= 1'b0;
      end else if (flush) begin
        q_valid  <= 1'b0;
      end else if (advance) begin
        q_valid  <= v_in;
        q_data   <= d_nxt;
        q_sticky <= st_nxt;
      end
    end

    // Amount, mode and sign only travel on to stages that still need them.
    if (k < SW - 1) begin : g_fwd
      logic [R-2:0] q_amt;
      op_e          q_op;
      logic         q_sign;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_amt  <= '0;
          q_op   <= OP_SHL;
          q_sign <= 1'b0;
        end else if (advance && !flush) begin
          q_amt  <= a_in[R-1:1];
          q_op   <= o_in;
          q_sign <= sg_in;
        end
      end
    end
  end

  assign out_valid = g_stage[SW-1].q_valid;
  assign out_data  = g_stage[SW-1].q_data;
  assign out_cout  = g_stage[SW-1].q_sticky;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe
//   Directed and randomised checks of shift_unit_pipe at WIDTH 16, 8 and 32.
//   Expected results come from a bit-by-bit reference function.
module tb_shift_unit_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH = 16
  logic        iv16, ir16, ov16, or16, oc16, oz16;
  logic [15:0] id16, od16;
  logic [3:0]  ia16;
  logic [1:0]  io16;
  // WIDTH = 8
  logic        iv8, ir8, ov8, or8, oc8, oz8;
  logic [7:0]  id8, od8;
  logic [2:0]  ia8;
  logic [1:0]  io8;
  // WIDTH = 32
  logic        iv32, ir32, ov32, or32, oc32, oz32;
  logic [31:0] id32, od32;
  logic [4:0]  ia32;
  logic [1:0]  io32;

  shift_unit_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_amt(ia16), .in_op(io16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16), .out_cout(oc16), .out_zero(oz16)
  );

  shift_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amt(ia8), .in_op(io8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_cout(oc8), .out_zero(oz8)
  );

  shift_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_amt(ia32), .in_op(io32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_cout(oc32), .out_zero(oz32)
  );

  // Returns {cout, result}; result in the low w bits.
  function automatic logic [32:0] ref_shift(input int w, input logic [31:0] d,
                                            input int a, input logic [1:0] op);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'd0:    if (i >= a) r[i] = d[i-a];
        2'd1:    if (i + a < w) r[i] = d[i+a];
        2'd2:    r[i] = (i + a < w) ? d[i+a] : d[w-1];
        default: r[i] = d[(i - a + w) % w];
      endcase
      if (op == 2'd0 && i >= w - a) c |= d[i];
      if ((op == 2'd1 || op == 2'd2) && i < a) c |= d[i];
    end
    return {c, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation into an empty 16-bit pipe; lat counts edges from acceptance.
  task automatic xfer16(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op,
                        output logic [15:0] rd, output logic rc, output logic rz,
                        output int lat);
    iv16 = 1'b1; id16 = d; ia16 = a; io16 = op;
    tick();
    iv16 = 1'b0;
    lat = 1;
    while (ov16 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    rd = od16; rc = oc16; rz = oz16;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ov16 !== 1'b0)     $display("FAIL rst_out_valid: got %b expected 0", ov16);
    if (ov16 !== 1'b0) errors++;
    checks++; if (od16 !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h expected 0000", od16); end
    checks++; if (oc16 !== 1'b0)     begin errors++; $display("FAIL rst_out_cout: got %b expected 0", oc16); end
    checks++; if (oz16 !== 1'b1)     begin errors++; $display("FAIL rst_out_zero: got %b expected 1", oz16); end
    checks++; if (ir16 !== 1'b1)     begin errors++; $display("FAIL rst_in_ready: got %b expected 1", ir16); end
    #19 rst_n = 1'b1;
    tick();
    checks++; if (ov16 !== 1'b0)     begin errors++; $display("FAIL rst_release_valid: got %b expected 0", ov16); end
  endtask

  task automatic run_table16(input string tag, input int n,
                             input logic [15:0] td [8], input logic [3:0] ta [8],
                             input logic [1:0] to [8], input logic [15:0] te [8],
                             input logic tc [8]);
    logic [15:0] rd;
    logic        rc, rz;
    int          lat;
    for (int i = 0; i < n; i++) begin
      xfer16(td[i], ta[i], to[i], rd, rc, rz, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL %s%0d_latency: got %0d expected 4", tag, i, lat); end
      checks++;
      if (rd !== te[i]) begin errors++; $display("FAIL %s%0d_data: got %h expected %h", tag, i, rd, te[i]); end
      checks++;
      if (rc !== tc[i]) begin errors++; $display("FAIL %s%0d_cout: got %b expected %b", tag, i, rc, tc[i]); end
      checks++;
      if (rz !== (te[i] == 16'h0)) begin errors++; $display("FAIL %s%0d_zero: got %b expected %b", tag, i, rz, te[i] == 16'h0); end
      tick();
    end
  endtask

  task automatic test_modes;
    logic [15:0] td [8];
    logic [3:0]  ta [8];
    logic [1:0]  to [8];
    logic [15:0] te [8];
    logic        tc [8];
    or16 = 1'b1;
    td = '{16'h8001, 16'h0018, 16'h8000, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0};
    ta = '{4'd1, 4'd4, 4'd15, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    to = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    te = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0018, 16'h0, 16'h0, 16'h0, 16'h0};
    tc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_table16("mode", 4, td, ta, to, te, tc);
  endtask

  task automatic test_edges;
    logic [15:0] td [8];
    logic [3:0]  ta [8];
    logic [1:0]  to [8];
    logic [15:0] te [8];
    logic        tc [8];
    td = '{16'h1234, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    ta = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    to = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    te = '{16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    tc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_table16("edge", 4, td, ta, to, te, tc);
  endtask

  task automatic test_backpressure;
    logic [15:0] d [10];
    logic [3:0]  a [10];
    logic [1:0]  o [10];
    logic [32:0] e;
    logic [15:0] held;
    int          sent, recv, cyc, extra;
    bit          stall;
    sent = 0; recv = 0; cyc = 0; extra = 0; held = '0;
    for (int i = 0; i < 10; i++) begin
      d[i] = 16'($urandom);
      a[i] = 4'($urandom_range(0, 15));
      o[i] = 2'($urandom_range(0, 3));
    end
    while (recv < 10 && cyc < 100) begin
      stall = (cyc >= 6 && cyc <= 8);
      or16  = !stall;
      iv16  = (sent < 10);
      if (sent < 10) begin id16 = d[sent]; ia16 = a[sent]; io16 = o[sent]; end
      @(negedge clk);
      if (stall) begin
        checks++;
        if (ir16 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", cyc, ir16); end
        if (cyc == 6) held = od16;
        else begin
          checks++;
          if (od16 !== held) begin errors++; $display("FAIL bp_hold cyc%0d: got %h expected %h", cyc, od16, held); end
        end
      end
      if (ov16 && or16) begin
        e = ref_shift(16, {16'h0, d[recv]}, int'(a[recv]), o[recv]);
        checks++;
        if (od16 !== e[15:0]) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", recv, od16, e[15:0]); end
        checks++;
        if (oc16 !== e[32]) begin errors++; $display("FAIL bp_cout%0d: got %b expected %b", recv, oc16, e[32]); end
        recv++;
      end
      if (iv16 && ir16) sent++;
      tick();
      cyc++;
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    checks++;
    if (recv !== 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", recv); end
    repeat (6) begin
      @(negedge clk);
      if (ov16) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL bp_extra: got %0d expected 0", extra); end
    tick();
  endtask

  task automatic test_flush;
    logic [15:0] rd;
    logic        rc, rz;
    int          lat, extra;
    extra = 0;
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv16 = 1'b1; id16 = 16'h00F0 + 16'(i); ia16 = 4'd1; io16 = 2'd0;
      tick();
    end
    flush = 1'b1;
    id16 = 16'hFFFF; ia16 = 4'd0; io16 = 2'd0;
    tick();
    flush = 1'b0;
    iv16 = 1'b0;
    checks++;
    if (ov16 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ov16); end
    xfer16(16'hC00F, 4'd2, 2'd0, rd, rc, rz, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL flush_latency: got %0d expected 4", lat); end
    checks++;
    if (rd !== 16'h003C) begin errors++; $display("FAIL flush_data: got %h expected 003c", rd); end
    checks++;
    if (rc !== 1'b1) begin errors++; $display("FAIL flush_cout: got %b expected 1", rc); end
    repeat (6) begin
      tick();
      if (ov16) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL flush_extra: got %0d expected 0", extra); end
  endtask

  task automatic test_async_reset;
    int extra;
    extra = 0;
    or16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv16 = 1'b1;
      id16 = (i == 0) ? 16'h00FF : 16'hA5A5;
      ia16 = 4'd4;
      io16 = 2'd0;
      tick();
    end
    iv16 = 1'b0;
    checks++;
    if (ov16 !== 1'b1 || od16 !== 16'h0FF0) begin
      errors++; $display("FAIL arst_pre: got valid=%b data=%h expected valid=1 data=0ff0", ov16, od16);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov16 !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", ov16); end
    checks++;
    if (od16 !== 16'h0000) begin errors++; $display("FAIL arst_data: got %h expected 0000", od16); end
    checks++;
    if (oz16 !== 1'b1) begin errors++; $display("FAIL arst_zero: got %b expected 1", oz16); end
    checks++;
    if (ir16 !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b expected 1", ir16); end
    iv16 = 1'b1; id16 = 16'h1111; ia16 = 4'd0; io16 = 2'd0;
    tick();
    tick();
    iv16 = 1'b0;
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ov16) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL arst_stale: got %0d expected 0", extra); end
    tick();
  endtask

  task automatic test_sweep8;
    logic [7:0]  d [32];
    int          a [32];
    logic [1:0]  o [32];
    logic [32:0] e;
    int          sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    for (int i = 0; i < 32; i++) begin
      d[i] = 8'($urandom);
      a[i] = i % 8;
      o[i] = 2'(i / 8);
    end
    while (recv < 32 && cyc < 1000) begin
      or8 = ($urandom_range(0, 3) != 0);
      iv8 = (sent < 32) && ($urandom_range(0, 4) != 0);
      if (sent < 32) begin id8 = d[sent]; ia8 = 3'(a[sent]); io8 = o[sent]; end
      @(negedge clk);
      if (ov8 && or8) begin
        e = ref_shift(8, {24'h0, d[recv]}, a[recv], o[recv]);
        checks++;
        if (od8 !== e[7:0]) begin errors++; $display("FAIL w8_data%0d: got %h expected %h", recv, od8, e[7:0]); end
        checks++;
        if (oc8 !== e[32]) begin errors++; $display("FAIL w8_cout%0d: got %b expected %b", recv, oc8, e[32]); end
        checks++;
        if (oz8 !== (e[7:0] == 8'h0)) begin errors++; $display("FAIL w8_zero%0d: got %b expected %b", recv, oz8, e[7:0] == 8'h0); end
        recv++;
      end
      if (iv8 && ir8) sent++;
      tick();
      cyc++;
    end
    iv8 = 1'b0;
    checks++;
    if (recv !== 32) begin errors++; $display("FAIL w8_count: got %0d expected 32", recv); end
  endtask

  task automatic test_sweep32;
    logic [31:0] d [128];
    int          a [128];
    logic [1:0]  o [128];
    logic [32:0] e;
    int          sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    for (int i = 0; i < 128; i++) begin
      d[i] = $urandom;
      a[i] = i % 32;
      o[i] = 2'(i / 32);
    end
    while (recv < 128 && cyc < 2000) begin
      or32 = ($urandom_range(0, 3) != 0);
      iv32 = (sent < 128) && ($urandom_range(0, 4) != 0);
      if (sent < 128) begin id32 = d[sent]; ia32 = 5'(a[sent]); io32 = o[sent]; end
      @(negedge clk);
      if (ov32 && or32) begin
        e = ref_shift(32, d[recv], a[recv], o[recv]);
        checks++;
        if (od32 !== e[31:0]) begin errors++; $display("FAIL w32_data%0d: got %h expected %h", recv, od32, e[31:0]); end
        checks++;
        if (oc32 !== e[32]) begin errors++; $display("FAIL w32_cout%0d: got %b expected %b", recv, oc32, e[32]); end
        checks++;
        if (oz32 !== (e[31:0] == 32'h0)) begin errors++; $display("FAIL w32_zero%0d: got %b expected %b", recv, oz32, e[31:0] == 32'h0); end
        recv++;
      end
      if (iv32 && ir32) sent++;
      tick();
      cyc++;
    end
    iv32 = 1'b0;
    checks++;
    if (recv !== 128) begin errors++; $display("FAIL w32_count: got %0d expected 128", recv); end
  endtask

  initial begin
    iv16 = 1'b0; id16 = '0; ia16 = '0; io16 = '0; or16 = 1'b1;
    iv8  = 1'b0; id8  = '0; ia8  = '0; io8  = '0; or8  = 1'b1;
    iv32 = 1'b0; id32 = '0; ia32 = '0; io32 = '0; or32 = 1'b1;
    test_reset();
    test_modes();
    test_edges();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_sweep8();
    test_sweep32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
